writeback_stage: RTL
====================

Name: writeback_stage

Overview:
- Write side of the register file: MEM/WB pipeline register plus write-port driver for the LEGv8 pipeline.
- Produces regWrite_W, wa3_W and writeData3_W, which feed the decode stage's regWrite_D, wa3_D and writeData3_D inputs.
- Handles variable-latency data-memory load responses: holds a pending load and back-pressures the MEM stage until the data arrives.
- Keeps a saturating load-stall counter for performance measurement.

Parameters:
- N, 64, datapath width.
- CW, 32, width of the stall counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- valid_M  in  1  MEM stage presents an instruction this cycle
- regWrite_M  in  1  instruction writes the register file
- memtoReg_M  in  1  1 = load (write memory data), 0 = write aluResult_M
- wa3_M  in  5  destination register
- aluResult_M  in  N  ALU result
- memValid_M  in  1  data-memory read data valid this cycle
- readData_M  in  N  data-memory read data
- ra1_D  in  5  decode read address 1 (bypass compare)
- ra2_D  in  5  decode read address 2 (bypass compare)
- stall_W  out  1  MEM stage must hold its outputs
- regWrite_W  out  1  register-file write enable
- wa3_W  out  5  register-file write address
- writeData3_W  out  N  register-file write data
- byp1_W  out  1  writeData3_W is a bypass for ra1_D
- byp2_W  out  1  writeData3_W is a bypass for ra2_D
- stallCnt_W  out  CW  total cycles spent in WAIT, saturating

Behaviour:
- Clock and reset:
  - Single clock, rising edge.
  - When reset=1 at an edge: state=IDLE; regWrite_W=0, wa3_W=0, writeData3_W=0, stall_W=0, stallCnt_W=0, byp*_W=0.
  - Reset during WAIT discards the pending load; no register write occurs.
- FSM states: IDLE, WAIT. stall_W = (state==WAIT), driven from a register.
- IDLE, valid_M=0:
  - Next cycle regWrite_W=0.
  - wa3_W and writeData3_W hold their previous values.
- IDLE, valid_M=1, memtoReg_M=0:
  - Next cycle regWrite_W=regWrite_M, wa3_W=wa3_M, writeData3_W=aluResult_M.
  - Latency 1.
- IDLE, valid_M=1, memtoReg_M=1, memValid_M=1:
  - Same as the non-load case, with writeData3_W=readData_M.
  - Latency 1.
- IDLE, valid_M=1, memtoReg_M=1, memValid_M=0:
  - Latch regWrite_M and wa3_M into pending registers.
  - Next state WAIT; next cycle regWrite_W=0.
- WAIT:
  - valid_M and the other instruction fields are ignored; upstream holds them while stall_W=1.
  - Each cycle in WAIT, stallCnt_W increments by 1 and saturates at 2^CW-1.
  - On memValid_M=1: next cycle regWrite_W=pending regWrite, wa3_W=pending wa3, writeData3_W=readData_M; state returns to IDLE and stall_W=0.
  - The MEM instruction held during the WAIT cycle in which memValid_M=1 arrives is not consumed. It is accepted in the following IDLE cycle.
- XZR: when the address being written is 31, regWrite_W is forced to 0 (wa3_W and writeData3_W update normally).
- No combinational path from M inputs to any W output. All outputs are registered, except byp*_W, which compare registered W state with ra*_D.
- stallCnt_W is cleared only by reset.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - byp1_W = regWrite_W && (wa3_W==ra1_D) && (ra1_D!=31).
  - byp2_W is the same using ra2_D.
  - Combinational. Lets decode forward the write value in the same cycle as the register-file write.
- Undefined:
  - byp1_W and byp2_W are tied to 0.
  - ra1_D and ra2_D are unused.
  - Port list is unchanged.

Test Plan:
- Reset with valid_M=1, regWrite_M=1, wa3_M=3:
  - During reset and on the first edge after reset, regWrite_W=0, stall_W=0, stallCnt_W=0.
- ALU write, valid_M=1, regWrite_M=1, memtoReg_M=0, wa3_M=5, aluResult_M=0x1234:
  - Next cycle regWrite_W=1, wa3_W=5, writeData3_W=0x1234.
  - Following cycle with valid_M=0: regWrite_W=0.
- Late load: valid_M=1, memtoReg_M=1, wa3_M=9, memValid_M=0; memValid_M asserted 3 cycles later with readData_M=0xDEAD:
  - stall_W=1 for 3 cycles, regWrite_W=0 throughout.
  - Then regWrite_W=1, wa3_W=9, writeData3_W=0xDEAD.
  - stallCnt_W=3.
- XZR write, wa3_M=31, regWrite_M=1, aluResult_M=0xFF:
  - regWrite_W=0.
  - With WB_BYPASS_EN and ra1_D=31: byp1_W=0.
- Reset asserted on the second WAIT cycle of a pending load to X7:
  - Returns to IDLE; no write to X7 ever occurs, even if memValid_M=1 afterwards.
- WB_BYPASS_EN defined, ALU write to X4 with ra1_D=4, ra2_D=6:
  - byp1_W=1, byp2_W=0 in the cycle regWrite_W=1.
  - With the macro undefined, both are 0.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register and register-file write driver with load wait; WB_BYPASS_EN enables decode bypass flags
module writeback_stage #(
    parameter int N  = 64,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_M,
    input  logic          regWrite_M,
    input  logic          memtoReg_M,
    input  logic [4:0]    wa3_M,
    input  logic [N-1:0]  aluResult_M,
    input  logic          memValid_M,
    input  logic [N-1:0]  readData_M,
    input  logic [4:0]    ra1_D,
    input  logic [4:0]    ra2_D,
    output logic          stall_W,
    output logic          regWrite_W,
    output logic [4:0]    wa3_W,
    output logic [N-1:0]  writeData3_W,
    output logic          byp1_W,
    output logic          byp2_W,
    output logic [CW-1:0] stallCnt_W
);
    typedef enum logic {IDLE, WAIT} state_e;
    state_e     state, state_d;
    logic       accept, pend_rw;
    logic [4:0] pend_wa;
    assign accept = valid_M && (!memtoReg_M || memValid_M);
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            regWrite_W   <= 1'b0;
            wa3_W        <= '0;
            writeData3_W <= '0;
            pend_rw      <= 1'b0;
            pend_wa      <= '0;
            stallCnt_W   <= '0;
        end else begin
            state <= state_d;
            if (state == WAIT) begin
                if (stallCnt_W != '1) stallCnt_W <= stallCnt_W + 1'b1;
                regWrite_W <= memValid_M && pend_rw && pend_wa != 5'd31;
                if (memValid_M) begin
                    wa3_W        <= pend_wa;
                    writeData3_W <= readData_M;
                end
            end else if (accept) begin
                regWrite_W   <= regWrite_M && wa3_M != 5'd31;
                wa3_W        <= wa3_M;
                writeData3_W <= memtoReg_M ? readData_M : aluResult_M;
            end else begin
                regWrite_W <= 1'b0;
                pend_rw    <= regWrite_M;
                pend_wa    <= wa3_M;
            end
        end
    end
    always_comb begin
        state_d = state;
        if (state == IDLE && valid_M && memtoReg_M && !memValid_M) state_d = WAIT;
        if (state == WAIT && memValid_M) state_d = IDLE;
    end
    always_comb begin
        stall_W = state == WAIT;
`ifdef WB_BYPASS_EN
        byp1_W = regWrite_W && wa3_W == ra1_D && ra1_D != 5'd31;
        byp2_W = regWrite_W && wa3_W == ra2_D && ra2_D != 5'd31;
`else
        byp1_W = 1'b0;
        byp2_W = 1'b0;
`endif
    end
`ifndef WB_BYPASS_EN
    logic unused_ra;
    assign unused_ra = ^{ra1_D, ra2_D};
`endif
endmodule
